// File: rtl/dfp128_cvt_support_if.sv
// Bus bundle for the binary128 to decimal128 conversion support block:
// decomposer, leading-zero counter and decimal128 packer signals.
interface dfp128_cvt_support_if;
  // Decomposer
  logic         ce;
  logic [127:0] fp_i;
  logic         sgn;
  logic [14:0]  exp;
  logic [111:0] man;
  logic [112:0] fract;
  logic         xz;
  logic         vz;
  logic         xinf;
  logic         inf;
  logic         nan;
  logic         qnan;
  logic         snan;
  // Leading-zero counter
  logic [191:0] lz_i;
  logic [7:0]   lz_o;
  // Packer
  logic         p_nan;
  logic         p_qnan;
  logic         p_snan;
  logic         p_inf;
  logic         p_sign;
  logic [13:0]  p_exp;
  logic [135:0] p_sig;
  logic [127:0] p_o;

  modport master (
    output ce, fp_i, lz_i,
    output p_nan, p_qnan, p_snan, p_inf, p_sign, p_exp, p_sig,
    input  sgn, exp, man, fract, xz, vz, xinf, inf, nan, qnan, snan,
    input  lz_o, p_o
  );

  modport slave (
    input  ce, fp_i, lz_i,
    input  p_nan, p_qnan, p_snan, p_inf, p_sign, p_exp, p_sig,
    output sgn, exp, man, fract, xz, vz, xinf, inf, nan, qnan, snan,
    output lz_o, p_o
  );
endinterface

// File: rtl/dfp128_cvt_support.sv
// Support block for binary128 -> decimal128 conversion: registered binary128
// decomposer, registered 192-bit leading-zero counter, combinational DPD packer.
module dfp128_cvt_support (
  input  logic                       clk,
  input  logic                       rst,
  dfp128_cvt_support_if.slave        bus
);

  // Densely packed decimal encoding of three BCD digits abcd efgh ijkm.
  function automatic logic [9:0] dpd_encode(input logic [11:0] dig);
    logic a, b, c, d, e, f, g, h, i, j, k, m;
    logic [9:0] r;
    {a, b, c, d} = dig[11:8];
    {e, f, g, h} = dig[7:4];
    {i, j, k, m} = dig[3:0];
    unique case ({a, e, i})
      3'b000:  r = {b, c, d, f, g, h, 1'b0, j, k, m};
      3'b001:  r = {b, c, d, f, g, h, 1'b1, 2'b00, m};
      3'b010:  r = {b, c, d, j, k, h, 1'b1, 2'b01, m};
      3'b011:  r = {b, c, d, 2'b10, h, 1'b1, 2'b11, m};
      3'b100:  r = {j, k, d, f, g, h, 1'b1, 2'b10, m};
      3'b101:  r = {f, g, d, 2'b01, h, 1'b1, 2'b11, m};
      3'b110:  r = {j, k, d, 2'b00, h, 1'b1, 2'b11, m};
      default: r = {2'b00, d, 2'b11, h, 1'b1, 2'b11, m};
    endcase
    return r;
  endfunction

  // ---------------- Decomposer ----------------
  logic [14:0]  d_exp;
  logic [111:0] d_man;
  logic         d_xz, d_xinf, d_man_zero;

  assign d_exp      = bus.fp_i[126:112];
  assign d_man      = bus.fp_i[111:0];
  assign d_xz       = (d_exp == 15'h0000);
  assign d_xinf     = (d_exp == 15'h7FFF);
  assign d_man_zero = (d_man == 112'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sgn   <= 1'b0;
      bus.exp   <= '0;
      bus.man   <= '0;
      bus.fract <= '0;
      bus.xz    <= 1'b0;
      bus.vz    <= 1'b0;
      bus.xinf  <= 1'b0;
      bus.inf   <= 1'b0;
      bus.nan   <= 1'b0;
      bus.qnan  <= 1'b0;
      bus.snan  <= 1'b0;
    end else if (bus.ce) begin
      bus.sgn   <= bus.fp_i[127];
      bus.exp   <= d_exp;
      bus.man   <= d_man;
      bus.fract <= {~d_xz, d_man};
      bus.xz    <= d_xz;
      bus.vz    <= d_xz & d_man_zero;
      bus.xinf  <= d_xinf;
      bus.inf   <= d_xinf & d_man_zero;
      bus.nan   <= d_xinf & ~d_man_zero;
      bus.qnan  <= d_xinf & ~d_man_zero & d_man[111];
      bus.snan  <= d_xinf & ~d_man_zero & ~d_man[111];
    end
  end

  // ---------------- Leading-zero counter ----------------
  logic [7:0] lz_next;

  // NOTE: combinational blocks assign a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    lz_next = 8'd192;
    // Ascending scan: the highest set bit is the last one to write.
    for (int i = 0; i < 192; i++) begin
      if (bus.lz_i[i]) lz_next = 8'(191 - i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         bus.lz_o <= 8'd0;
    else if (bus.ce) bus.lz_o <= lz_next;
  end

  // ---------------- Decimal128 packer ----------------
  logic [3:0]   msd;
  logic [109:0] declets;
  logic [4:0]   comb_g;
  logic [11:0]  exp_cont;

  assign msd = bus.p_sig[135:132];

  always_comb begin
    declets = '0;
    for (int k = 0; k < 11; k++) begin
      declets[10*k +: 10] = dpd_encode(bus.p_sig[12*k +: 12]);
    end
  end

  // NaN outranks infinity; a NaN keeps digits 32..0 as its payload.
  always_comb begin
    comb_g   = 5'b00000;
    exp_cont = 12'h000;
    bus.p_o  = '0;
    if (bus.p_nan) begin
      comb_g   = 5'b11111;
      exp_cont = {bus.p_snan, 11'd0};
      bus.p_o  = {bus.p_sign, comb_g, exp_cont, declets};
    end else if (bus.p_inf) begin
      comb_g  = 5'b11110;
      bus.p_o = {bus.p_sign, comb_g, 122'd0};
    end else begin
      if (msd[3]) comb_g = {2'b11, bus.p_exp[13:12], msd[0]};
      else        comb_g = {bus.p_exp[13:12], msd[2:0]};
      exp_cont = bus.p_exp[11:0];
      bus.p_o  = {bus.p_sign, comb_g, exp_cont, declets};
    end
  end

endmodule

// File: tb/tb_dfp128_cvt_support.sv
// Directed self-checking bench for dfp128_cvt_support: decomposer, LZC and
// decimal128 packer against hand-computed expected values.
module tb_dfp128_cvt_support;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  dfp128_cvt_support_if bus ();

  dfp128_cvt_support dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] flags();
    return {bus.xz, bus.vz, bus.xinf, bus.inf, bus.nan, bus.qnan, bus.snan};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_sgn"},   192'(bus.sgn),   192'd0);
    check({tag, "_exp"},   192'(bus.exp),   192'd0);
    check({tag, "_man"},   192'(bus.man),   192'd0);
    check({tag, "_fract"}, 192'(bus.fract), 192'd0);
    check({tag, "_flags"}, 192'(flags()),   192'd0);
    check({tag, "_lz"},    192'(bus.lz_o),  192'd0);
  endtask

  logic [112:0] fract_one;
  logic [191:0] one192;

  initial begin
    fract_one = 113'd1 << 112;
    one192    = 192'd1;
    rst        = 1'b1;
    bus.ce     = 1'b1;
    bus.fp_i   = 128'h3FFF_0000_0000_0000_0000_0000_0000_0000;
    bus.lz_i   = 192'd0;
    bus.p_nan  = 1'b0;
    bus.p_qnan = 1'b0;
    bus.p_snan = 1'b0;
    bus.p_inf  = 1'b0;
    bus.p_sign = 1'b0;
    bus.p_exp  = 14'd0;
    bus.p_sig  = '0;

    // Reset state
    tick();
    check_all_zero("reset");
    rst = 1'b0;

    // 1.0 with LZC operand zero
    bus.lz_i = 192'd0;
    tick();
    check("one_sgn",   192'(bus.sgn),   192'd0);
    check("one_exp",   192'(bus.exp),   192'h3FFF);
    check("one_man",   192'(bus.man),   192'd0);
    check("one_fract", 192'(bus.fract), 192'(fract_one));
    check("one_flags", 192'(flags()),   192'd0);
    check("lz_zero",   192'(bus.lz_o),  192'd192);

    // ce=0 holds everything
    bus.ce   = 1'b0;
    bus.fp_i = 128'hFFFF_0000_0000_0000_0000_0000_0000_0000;
    bus.lz_i = one192 << 191;
    tick();
    check("hold_exp", 192'(bus.exp),  192'h3FFF);
    check("hold_sgn", 192'(bus.sgn),  192'd0);
    check("hold_lz",  192'(bus.lz_o), 192'd192);

    // Quiet NaN, LZC top bit set
    bus.ce   = 1'b1;
    bus.fp_i = 128'h7FFF_8000_0000_0000_0000_0000_0000_0000;
    tick();
    check("qnan_flags", 192'(flags()),  192'(7'b0010110));
    check("lz_top",     192'(bus.lz_o), 192'd0);

    // Signaling NaN, LZC bit 0
    bus.fp_i = 128'h7FFF_0000_0000_0000_0000_0000_0000_0001;
    bus.lz_i = one192;
    tick();
    check("snan_flags", 192'(flags()),  192'(7'b0010101));
    check("lz_bit0",    192'(bus.lz_o), 192'd191);

    // Negative infinity, LZC bit 100
    bus.fp_i = 128'hFFFF_0000_0000_0000_0000_0000_0000_0000;
    bus.lz_i = one192 << 100;
    tick();
    check("inf_sgn",   192'(bus.sgn),   192'd1);
    check("inf_flags", 192'(flags()),   192'(7'b0011000));
    check("inf_fract", 192'(bus.fract), 192'(fract_one));
    check("lz_bit100", 192'(bus.lz_o),  192'd91);

    // Zero
    bus.fp_i = 128'd0;
    tick();
    check("zero_flags", 192'(flags()),   192'(7'b1100000));
    check("zero_fract", 192'(bus.fract), 192'd0);

    // Reset wins over ce with a nonzero operand
    bus.fp_i = 128'hFFFF_0000_0000_0000_0000_0000_0000_0000;
    bus.lz_i = one192 << 5;
    rst = 1'b1;
    tick();
    check_all_zero("rst_mid");
    rst = 1'b0;

    // Packer, finite values
    bus.p_sig = 136'd1;
    bus.p_exp = 14'h1820;
    #1;
    check("pack_one", 192'(bus.p_o), 192'(128'h2208_0000_0000_0000_0000_0000_0000_0001));
    bus.p_sig = 136'h999;
    #1;
    check("pack_999", 192'(bus.p_o[9:0]), 192'(10'h0FF));
    bus.p_sig = 136'h123;
    #1;
    check("pack_123", 192'(bus.p_o[9:0]), 192'(10'h0A3));
    // Second declet carries digits 5..3
    bus.p_sig = 136'h456_000;
    #1;
    check("pack_decl1", 192'(bus.p_o[19:10]), 192'(10'h256));

    // MSD >= 8
    bus.p_sig = {4'h9, 132'd0};
    bus.p_exp = 14'd0;
    #1;
    check("pack_msd9", 192'(bus.p_o), 192'(128'h6400_0000_0000_0000_0000_0000_0000_0000));

    // Specials
    bus.p_sig  = 136'h123;
    bus.p_inf  = 1'b1;
    bus.p_sign = 1'b1;
    #1;
    check("pack_inf", 192'(bus.p_o), 192'(128'hF800_0000_0000_0000_0000_0000_0000_0000));
    bus.p_inf  = 1'b0;
    bus.p_sign = 1'b0;
    bus.p_nan  = 1'b1;
    bus.p_sig  = 136'd0;
    #1;
    check("pack_qnan", 192'(bus.p_o), 192'(128'h7C00_0000_0000_0000_0000_0000_0000_0000));
    bus.p_snan = 1'b1;
    #1;
    check("pack_snan", 192'(bus.p_o), 192'(128'h7E00_0000_0000_0000_0000_0000_0000_0000));
    bus.p_snan = 1'b0;
    bus.p_inf  = 1'b1;
    bus.p_sig  = 136'h123;
    rst        = 1'b1;
    #1;
    check("pack_nan_inf", 192'(bus.p_o), 192'(128'h7C00_0000_0000_0000_0000_0000_0000_00A3));
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dfp128_cvt_support.md
Name: dfp128_cvt_support

Overview:
- Support block for the binary128 to decimal128 converter. It contains three independent functions sharing clk/rst:
  - a registered IEEE binary128 decomposer;
  - a registered 192-bit leading-zero counter;
  - a combinational packer from unpacked decimal fields to IEEE 754-2008 decimal128 DPD encoding.
- The converter uses the decomposer on its input, the LZC to normalise the BCD significand, and the packer on its output.

Parameters:
- None. Widths are fixed: EMSB=14, FMSB=111.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ce  in  1  clock enable for the decomposer and LZC registers
- fp_i  in  128  binary128 operand
- sgn  out  1  sign, fp_i[127]
- exp  out  15  biased exponent, fp_i[126:112]
- man  out  112  stored fraction, fp_i[111:0]
- fract  out  113  significand with hidden bit
- xz  out  1  exponent is zero
- vz  out  1  value is ±0
- xinf  out  1  exponent is all ones
- inf  out  1  infinity
- nan  out  1  NaN
- qnan  out  1  quiet NaN
- snan  out  1  signaling NaN
- lz_i  in  192  LZC operand
- lz_o  out  8  leading-zero count, 0..192
- p_nan, p_qnan, p_snan, p_inf, p_sign  in  1 each  unpacked decimal flags
- p_exp  in  14  biased decimal exponent (bias 6176)
- p_sig  in  136  34 BCD digits; MSD in [135:132], LSD in [3:0]
- p_o  out  128  packed decimal128

Behaviour:
- Decomposer: registered, 1-cycle latency, updates only when ce=1.
  - xz = (exp==0)
  - vz = xz & (man==0)
  - xinf = (exp==15'h7FFF)
  - inf = xinf & (man==0)
  - nan = xinf & (man!=0)
  - qnan = nan & man[111]
  - snan = nan & ~man[111]
  - fract = {~xz, man}
- LZC: registered, 1-cycle latency, gated by ce.
  - lz_o = number of consecutive zeros from bit 191 downward.
  - lz_i==0 gives 192.
- rst (synchronous) clears every registered output to 0, including lz_o, and takes priority over ce.
- ce=0 holds all registered outputs.
- Packer: purely combinational, not affected by rst. Field layout:
  - p_o[127] = p_sign
  - p_o[126:122] = combination field G
  - p_o[121:110] = exponent continuation
  - p_o[109:0] = 11 declets
- Packer field selection, in priority order:
  - p_nan: G=11111; p_o[121]=p_snan; p_o[120:110]=0; declets = DPD of digits 32..0 (payload).
  - else p_inf: G=11110; all other bits except sign are 0.
  - else, with d = MSD (p_sig[135:132]):
    - d<8: G = {p_exp[13:12], d[2:0]}.
    - d>=8: G = {2'b11, p_exp[13:12], d[0]}.
    - p_o[121:110] = p_exp[11:0].
- Declet k (k=0 at LSB, p_o[10k+9:10k]) encodes digits 3k+2, 3k+1, 3k. Write these digits as bits abcd, efgh, ijkm. Encoding is selected by (a,e,i):
  - 000 → bcd fgh 0 jkm
  - 001 → bcd fgh 1 00m
  - 010 → bcd jkh 1 01m
  - 011 → bcd 10h 1 11m
  - 100 → jkd fgh 1 10m
  - 101 → fgd 01h 1 11m
  - 110 → jkd 00h 1 11m
  - 111 → 00d 11h 1 11m
- Non-BCD digit codes (>9) are encoded through the same table without error flagging.
- p_qnan is informational only: quiet is implied by p_nan & ~p_snan.

Test Plan:
- Decomposer, normal operand: ce=1, fp_i=128'h3FFF_0000…0 (1.0).
  - Next cycle: sgn=0, exp=15'h3FFF, man=0, fract=113'h1<<112.
  - xz=vz=xinf=inf=nan=0.
  - Then ce=0 with new fp_i: outputs hold.
- Decomposer, specials:
  - fp_i=128'h7FFF_8000_0…0 → xinf=1, nan=1, qnan=1, snan=0.
  - fp_i=128'hFFFF_0…0 → sgn=1, inf=1, nan=0.
  - fp_i=0 → xz=1, vz=1, fract=0.
  - Assert rst in any of these cases → all outputs 0 next cycle.
- LZC, one cycle after each input:
  - lz_i=0 → 192.
  - lz_i=1<<191 → 0.
  - lz_i=1 → 191.
  - lz_i=1<<100 → 91.
  - rst → 0.
- Pack, finite values:
  - p_sig=1, p_exp=14'h1820, p_sign=0 → p_o=128'h2208_0000_0000_0000_0000_0000_0000_0001.
  - Low three digits 999 → low declet 10'h0FF.
  - Low three digits 123 → low declet 10'h0A3.
- Pack, MSD≥8: p_sig MSD=9, other digits 0, p_exp=0 → p_o=128'h6400_0…0.
- Pack, specials:
  - p_inf=1, p_sign=1 → 128'hF800_0…0.
  - p_nan=1, p_snan=0, sig=0 → 128'h7C00_0…0.
  - p_nan=1, p_snan=1 → 128'h7E00_0…0.
  - p_nan and p_inf both set → NaN encoding.
